mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter for the shared RAM port on the processor system bus.
- Requester 0 is the CPU sequencer's memory access; requester 1 is a front-panel program loader that writes switch values into RAM.
- It latches the winning request, drives the RAM control and address/data for a fixed number of access cycles, and returns read data with a one-cycle done pulse.
- It sits between the requesters and the ram block; the ram block itself is unchanged.

Parameters:
WORD_W, 8, data word width
ADDR_W, 5, RAM address width (WORD_W - OP_W for the default processor)
ACC_CYC, 2, cycles mem_CS is held per access; legal range 1..15

Ports:
clock  input  1  system clock; all state updates on rising edge
n_reset  input  1  asynchronous active-low reset
req0  input  1  requester 0 access request; held high until done0
rnw0  input  1  requester 0 direction: 1 = read, 0 = write
addr0  input  ADDR_W  requester 0 address
wdata0  input  WORD_W  requester 0 write data
req1  input  1  requester 1 access request; held high until done1
rnw1  input  1  requester 1 direction
addr1  input  ADDR_W  requester 1 address
wdata1  input  WORD_W  requester 1 write data
gnt0  output  1  requester 0 owns the RAM port
gnt1  output  1  requester 1 owns the RAM port
done0  output  1  one-cycle completion pulse to requester 0
done1  output  1  one-cycle completion pulse to requester 1
rdata  output  WORD_W  read data; valid in the done cycle and held until the next read completes
mem_CS  output  1  RAM chip select
mem_R_NW  output  1  RAM read/not-write
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  WORD_W  RAM write data
mem_rdata  input  WORD_W  RAM read data

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of clock):
  - state = IDLE.
  - gnt0, gnt1, done0, done1, mem_CS = 0; mem_R_NW = 1.
  - mem_addr, mem_wdata, rdata = 0; cycle counter = 0.
  - last = 1, so requester 0 wins the first contested arbitration.
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE:
  - If no request is high, stay in IDLE.
  - If exactly one request is high, grant that requester.
  - If both are high, grant the requester that is not `last`.
  - On grant: register gnt, mem_addr, mem_wdata and mem_R_NW from the winner, set mem_CS = 1, set counter = ACC_CYC-1, set last = winner, and go to ACCESS.
  - Latency: a request sampled at edge N produces gnt and mem_CS high after edge N.
- ACCESS:
  - mem_CS, gnt and all latched fields are held stable.
  - Decrement the counter each cycle.
  - When counter = 0 at an edge: for a read, register mem_rdata into rdata; for a write, leave rdata unchanged. Then clear mem_CS, set mem_R_NW = 1, set done for the winner, and go to DONE.
  - mem_CS is high for exactly ACC_CYC cycles.
- DONE:
  - Lasts one cycle. done(winner) = 1 and gnt(winner) stays 1.
  - At the next edge, clear done and gnt and go to IDLE.
  - Requests are not evaluated in DONE. A requester that still holds req in the cycle after done is treated as making a new request.
- Total latency from request to done is ACC_CYC+1 cycles after the grant edge. The minimum request-to-request turnaround is ACC_CYC+2 cycles.
- Boundary conditions:
  - A req that drops mid-ACCESS does not abort the access. The access completes and done still pulses.
  - Address, data and rnw changes on the requester side after the grant are ignored because they are latched.
  - gnt0 and gnt1 are never high together. At most one done is high in any cycle.
  - With both requests held continuously, grants alternate 0,1,0,1...
  - ACC_CYC = 1: mem_CS is high for one cycle and DONE follows immediately.
  - Reset asserted mid-ACCESS or mid-DONE: the access is abandoned, no done pulse is produced, and outputs take reset values.

Test Plan:
- After reset, req0=1, rnw0=1, addr0=5'h03, RAM[3]=8'hA5, ACC_CYC=2 -> gnt0 and mem_CS high after the next edge; mem_CS high for 2 cycles; done0 pulses 1 cycle later with rdata=8'hA5; gnt1 stays 0 throughout.
- req1=1, rnw1=0, addr1=5'h1F, wdata1=8'h3C -> mem_R_NW=0, mem_addr=5'h1F, mem_wdata=8'h3C for 2 cycles; done1 pulses; a subsequent read of 1F returns 8'h3C; rdata is unchanged by the write.
- req0 and req1 raised in the same cycle straight after reset, and both held -> grant order 0,1,0,1 across four accesses; each done is ACC_CYC+2 cycles after the previous done; gnt0 and gnt1 are never high together.
- req0 access started, then addr0 changes and req0 drops in the first ACCESS cycle -> mem_addr keeps the original value; done0 still pulses; FSM returns to IDLE.
- n_reset pulled low during the second ACCESS cycle of a read -> mem_CS, gnt0 and done0 are 0 immediately with no clock edge needed; no done pulse; after release, simultaneous requests grant requester 0 first.
- ACC_CYC=1 build, single read -> mem_CS high for exactly 1 cycle; done0 in the following cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the shared RAM port.
// Latches the winner, runs a fixed-length access, pulses done.
module mem_arbiter #(
  parameter int WORD_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int ACC_CYC = 2
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              req0,
  input  logic              rnw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WORD_W-1:0] wdata0,
  input  logic              req1,
  input  logic              rnw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [WORD_W-1:0] rdata,
  output logic              mem_CS,
  output logic              mem_R_NW,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last;

  logic       any_req;
  logic       pick1;
  logic       start;
  logic       acc_end;

  // Arbitration: a lone request wins; on contention the
  // requester that did not win last time gets the port.
  always_comb begin
    any_req = req0 | req1;
    pick1   = req1 & (~req0 | ~last);
    start   = (state == IDLE) & any_req;
    acc_end = (state == ACCESS) & (cnt == 4'd0);
  end

  // Sequencer: state, access cycle counter and last winner.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state <= ACCESS;
            cnt   <= CNT_INIT;
            last  <= pick1;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Grant is held from the grant edge through the done cycle.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
    end else if (start) begin
      gnt0 <= ~pick1;
      gnt1 <= pick1;
    end else if (state == DONE) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
    end
  end

  // Done pulses for exactly the one DONE cycle of the owner.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else if (acc_end) begin
      done0 <= gnt0;
      done1 <= gnt1;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
    end
  end

  // RAM control: chip select spans the access cycles only.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mem_CS   <= 1'b0;
      mem_R_NW <= 1'b1;
    end else if (start) begin
      mem_CS   <= 1'b1;
      mem_R_NW <= pick1 ? rnw1 : rnw0;
    end else if (acc_end) begin
      mem_CS   <= 1'b0;
      mem_R_NW <= 1'b1;
    end
  end

  // Address and write data are latched at grant so requester
  // side changes during the access have no effect.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_addr  <= pick1 ? addr1 : addr0;
      mem_wdata <= pick1 ? wdata1 : wdata0;
    end
  end

  // Read data captured on the final access edge of a read;
  // writes leave the previous read value in place.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rdata <= '0;
    end else if (acc_end && mem_R_NW) begin
      rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: ACC_CYC=2 main instance
// plus an ACC_CYC=1 instance for the short-access case.
module tb_mem_arbiter;

  localparam int WW = 8;
  localparam int AW = 5;

  logic          clock;
  logic          n_reset;

  logic          req0, rnw0, req1, rnw1;
  logic [AW-1:0] addr0, addr1;
  logic [WW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [WW-1:0] rdata;
  logic          mem_CS, mem_R_NW;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata, mem_rdata;

  logic          b_req0, b_rnw0, b_req1, b_rnw1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [WW-1:0] b_wdata0, b_wdata1;
  logic          b_gnt0, b_gnt1, b_done0, b_done1;
  logic [WW-1:0] b_rdata;
  logic          b_mem_CS, b_mem_R_NW;
  logic [AW-1:0] b_mem_addr;
  logic [WW-1:0] b_mem_wdata, b_mem_rdata;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [WW-1:0] pre_data;
  logic [WW-1:0] ram [32];

  int checks = 0;
  int errors = 0;
  int n;
  int tdone [4];
  int ord [4];

  mem_arbiter #(.WORD_W(WW), .ADDR_W(AW), .ACC_CYC(2)) dut (
    .clock(clock), .n_reset(n_reset),
    .req0(req0), .rnw0(rnw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rnw1(rnw1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_CS(mem_CS), .mem_R_NW(mem_R_NW),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.WORD_W(WW), .ADDR_W(AW), .ACC_CYC(1)) dut1 (
    .clock(clock), .n_reset(n_reset),
    .req0(b_req0), .rnw0(b_rnw0), .addr0(b_addr0),
    .wdata0(b_wdata0),
    .req1(b_req1), .rnw1(b_rnw1), .addr1(b_addr1),
    .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0),
    .done1(b_done1),
    .rdata(b_rdata), .mem_CS(b_mem_CS),
    .mem_R_NW(b_mem_R_NW),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple RAM: combinational read, write on clock edge.
  always @(posedge clock) begin
    if (mem_CS && !mem_R_NW) ram[mem_addr] <= mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end
  assign mem_rdata = ram[mem_addr];

  // Second instance reads a pattern derived from the address.
  assign b_mem_rdata = {3'b101, b_mem_addr};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_reset = 1'b0;
    req0 = 0; rnw0 = 1; addr0 = '0; wdata0 = '0;
    req1 = 0; rnw1 = 1; addr1 = '0; wdata1 = '0;
    b_req0 = 0; b_rnw0 = 1; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_rnw1 = 1; b_addr1 = '0; b_wdata1 = '0;
    pre_we = 1'b1; pre_addr = 5'h03; pre_data = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      ord[i] = -1;
      tdone[i] = 0;
    end
    step();
    pre_we = 1'b0;
    step();

    // reset state
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_done", 32'({done0, done1}), 0);
    chk("rst_cs", 32'(mem_CS), 0);
    chk("rst_rnw", 32'(mem_R_NW), 1);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'(rdata), 0);

    // single read of RAM[3]
    n_reset = 1'b1;
    req0 = 1; rnw0 = 1; addr0 = 5'h03;
    step();
    chk("rd_gnt0", 32'(gnt0), 1);
    chk("rd_cs1", 32'(mem_CS), 1);
    chk("rd_addr", 32'(mem_addr), 32'h03);
    chk("rd_gnt1", 32'(gnt1), 0);
    step();
    chk("rd_cs2", 32'(mem_CS), 1);
    chk("rd_done_early", 32'(done0), 0);
    step();
    chk("rd_cs_off", 32'(mem_CS), 0);
    chk("rd_done0", 32'(done0), 1);
    chk("rd_rdata", 32'(rdata), 32'hA5);
    chk("rd_gnt0_done", 32'(gnt0), 1);
    chk("rd_gnt1_done", 32'(gnt1), 0);
    req0 = 0;
    step();
    chk("rd_idle_done", 32'(done0), 0);
    chk("rd_idle_gnt", 32'(gnt0), 0);

    // write 3C to 1F by requester 1
    req1 = 1; rnw1 = 0; addr1 = 5'h1F; wdata1 = 8'h3C;
    step();
    chk("wr_gnt1", 32'(gnt1), 1);
    chk("wr_gnt0", 32'(gnt0), 0);
    chk("wr_rnw", 32'(mem_R_NW), 0);
    chk("wr_addr", 32'(mem_addr), 32'h1F);
    chk("wr_wdata", 32'(mem_wdata), 32'h3C);
    chk("wr_cs1", 32'(mem_CS), 1);
    step();
    chk("wr_cs2", 32'(mem_CS), 1);
    chk("wr_rnw2", 32'(mem_R_NW), 0);
    step();
    chk("wr_done1", 32'(done1), 1);
    chk("wr_done0", 32'(done0), 0);
    chk("wr_cs_off", 32'(mem_CS), 0);
    chk("wr_rnw_back", 32'(mem_R_NW), 1);
    chk("wr_rdata_kept", 32'(rdata), 32'hA5);
    req1 = 0;
    step();

    // read back 1F
    req0 = 1; rnw0 = 1; addr0 = 5'h1F;
    step();
    step();
    step();
    chk("rb_done0", 32'(done0), 1);
    chk("rb_rdata", 32'(rdata), 32'h3C);
    req0 = 0;
    step();

    // contention straight after reset: 0,1,0,1
    n_reset = 1'b0;
    #1;
    step();
    n_reset = 1'b1;
    req0 = 1; rnw0 = 1; addr0 = 5'h03;
    req1 = 1; rnw1 = 1; addr1 = 5'h1F;
    n = 0;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      step();
      chk("rr_excl_gnt", 32'(gnt0 & gnt1), 0);
      chk("rr_excl_done", 32'(done0 & done1), 0);
      if (done0 || done1) begin
        ord[n] = done1 ? 1 : 0;
        tdone[n] = c;
        chk("rr_rdata", 32'(rdata),
            (n % 2 == 1) ? 32'h3C : 32'hA5);
        n++;
        if (n == 4) begin
          req0 = 0;
          req1 = 0;
        end
      end
    end
    chk("rr_count", n, 4);
    chk("rr_first", tdone[0], 3);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", ord[i], i % 2);
    end
    for (int i = 1; i < 4; i++) begin
      chk("rr_spacing", tdone[i] - tdone[i-1], 4);
    end
    step();
    chk("rr_end_gnt", 32'({gnt0, gnt1}), 0);

    // requester-side changes and req drop after grant
    req0 = 1; rnw0 = 1; addr0 = 5'h03;
    step();
    chk("hold_addr0", 32'(mem_addr), 32'h03);
    addr0 = 5'h10; rnw0 = 0; wdata0 = 8'hFF; req0 = 0;
    step();
    chk("hold_addr1", 32'(mem_addr), 32'h03);
    chk("hold_rnw", 32'(mem_R_NW), 1);
    chk("hold_cs", 32'(mem_CS), 1);
    chk("hold_wdata", 32'(mem_wdata), 32'h00);
    step();
    chk("hold_done0", 32'(done0), 1);
    chk("hold_rdata", 32'(rdata), 32'hA5);
    step();
    chk("hold_idle_gnt", 32'(gnt0), 0);
    chk("hold_idle_done", 32'(done0), 0);
    step();
    chk("hold_no_regrant", 32'(mem_CS), 0);

    // reset during the second access cycle of a read
    req0 = 1; rnw0 = 1; addr0 = 5'h03;
    step();
    step();
    chk("ar_cs_before", 32'(mem_CS), 1);
    n_reset = 1'b0;
    #1;
    chk("ar_cs", 32'(mem_CS), 0);
    chk("ar_gnt0", 32'(gnt0), 0);
    chk("ar_done0", 32'(done0), 0);
    chk("ar_rdata", 32'(rdata), 0);
    step();
    chk("ar_no_done", 32'(done0), 0);
    n_reset = 1'b1;
    req0 = 1; req1 = 1; rnw1 = 1; addr1 = 5'h1F;
    step();
    chk("ar_first_gnt0", 32'(gnt0), 1);
    chk("ar_first_gnt1", 32'(gnt1), 0);
    req0 = 0; req1 = 0;
    step();
    step();
    chk("ar_done_after", 32'(done0), 1);
    step();

    // ACC_CYC = 1 instance
    b_req0 = 1; b_rnw0 = 1; b_addr0 = 5'h07;
    step();
    chk("a1_cs", 32'(b_mem_CS), 1);
    chk("a1_gnt0", 32'(b_gnt0), 1);
    chk("a1_no_done", 32'(b_done0), 0);
    b_req0 = 0;
    step();
    chk("a1_cs_off", 32'(b_mem_CS), 0);
    chk("a1_done0", 32'(b_done0), 1);
    chk("a1_rdata", 32'(b_rdata), 32'hA7);
    chk("a1_gnt1", 32'(b_gnt1), 0);
    step();
    chk("a1_idle", 32'({b_gnt0, b_done0}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
